// File: rtl/dmem_arb_pkg.sv
// Shared state type, parameter limits and sizing helper for dmem_arb.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned NREQ_MIN    = 2;
  localparam int unsigned NREQ_MAX    = 4;
  localparam int unsigned LOCKMAX_MIN = 1;
  localparam int unsigned LOCKMAX_MAX = 15;

  // Counter must be able to hold the value LOCKMAX itself.
  function automatic int unsigned lock_cnt_w(input int unsigned lockmax);
    return $clog2(lockmax + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// rr_pick: combinational rotate-priority encoder; scans from ptr+1 upward modulo N.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic          found;
  logic [PW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = PW'((32'(ptr) + k) % N);
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: round-robin arbiter for the shared data-memory port.
// Optional lock (back-to-back exclusive grants) enabled by DMEM_ARB_LOCK_EN.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NBDATA  = 32,
  parameter int unsigned MDATAW  = 8,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LOCKMAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wr,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*MDATAW-1:0]   addr,
  input  logic [NREQ*NBDATA-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [NBDATA-1:0]        rdata,
  output logic                     mem_wr,
  output logic [MDATAW-1:0]        mem_addr,
  output logic [NBDATA-1:0]        mem_data_out,
  input  logic [NBDATA-1:0]        mem_data_in
);

  localparam int unsigned PW = $clog2(NREQ);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("dmem_arb: NREQ out of range");
  end
  if (LOCKMAX < LOCKMAX_MIN || LOCKMAX > LOCKMAX_MAX) begin : g_bad_lockmax
    $error("dmem_arb: LOCKMAX out of range");
  end

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] rr_gnt;
  logic [PW-1:0]   rr_idx;
  logic [PW-1:0]   win;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned CW = lock_cnt_w(LOCKMAX);

  arb_state_e    state;
  logic [PW-1:0] owner;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          own_req;

  assign own_req = (state == LOCKED) && req[owner];
  assign cnt_nxt = lock_cnt + 1'b1;

  always_comb begin
    if (own_req) begin
      gnt        = '0;
      gnt[owner] = 1'b1;
      win        = owner;
    end else begin
      gnt = rr_gnt;
      win = rr_idx;
    end
  end

  // Owner dropping req falls through to normal arbitration in the same cycle,
  // and that winner may itself start a new lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB;
      owner    <= '0;
      lock_cnt <= '0;
    end else if (own_req) begin
      lock_cnt <= cnt_nxt;
      if (!lock[owner] || cnt_nxt == CW'(LOCKMAX))
        state <= ARB;
    end else if (|rr_gnt && lock[rr_idx]) begin
      state    <= LOCKED;
      owner    <= rr_idx;
      lock_cnt <= '0;
    end else begin
      state <= ARB;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign gnt = rr_gnt;
  assign win = rr_idx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= PW'(NREQ - 1);
    else if (|gnt)
      ptr <= win;
  end

  always_comb begin
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_wr       = wr[i];
        mem_addr     = addr[i*MDATAW +: MDATAW];
        mem_data_out = wdata[i*NBDATA +: NBDATA];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= (|gnt && !mem_wr) ? gnt : '0;
      if (|gnt && !mem_wr)
        rdata <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Randomized + directed bench for dmem_arb against a behavioural arbitration model.
module tb_dmem_arb;

  localparam int NBDATA  = 32;
  localparam int MDATAW  = 8;
  localparam int NREQ    = 2;
  localparam int LOCKMAX = 4;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req, wr, lock;
  logic [NREQ*MDATAW-1:0] addr;
  logic [NREQ*NBDATA-1:0] wdata;
  logic [NREQ-1:0]        gnt, rvalid;
  logic [NBDATA-1:0]      rdata, mem_data_out, mem_data_in;
  logic                   mem_wr;
  logic [MDATAW-1:0]      mem_addr;

  logic [NBDATA-1:0] mem_img [256];

  dmem_arb #(
    .NBDATA  (NBDATA),
    .MDATAW  (MDATAW),
    .NREQ    (NREQ),
    .LOCKMAX (LOCKMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .wr           (wr),
    .lock         (lock),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  always #5 clk = ~clk;

  // Asynchronous-read memory image feeding the arbiter.
  assign mem_data_in = mem_img[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: last granted index, lock ownership, expected read return.
  int                m_last;
  bit                m_locked;
  int                m_owner;
  int                m_cnt;
  logic [NREQ-1:0]   exp_rvalid;
  logic [NBDATA-1:0] exp_rdata;
  logic [NREQ-1:0]   seen_gnt, seen_rvalid;
  logic [NBDATA-1:0] seen_rdata;

  task automatic model_reset();
    m_last     = NREQ - 1;
    m_locked   = 1'b0;
    m_owner    = 0;
    m_cnt      = 0;
    exp_rvalid = '0;
    exp_rdata  = '0;
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    int j;
    if (LOCK_ON && m_locked && r[m_owner]) return m_owner;
    for (int k = 1; k <= NREQ; k++) begin
      j = (m_last + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                      input logic [NREQ-1:0] l, input logic [NREQ*MDATAW-1:0] a,
                      input logic [NREQ*NBDATA-1:0] d);
    int                win;
    logic [NREQ-1:0]   e_gnt;
    logic              e_wr;
    logic [MDATAW-1:0] e_addr;
    logic [NBDATA-1:0] e_data;
    req = r; wr = w; lock = l; addr = a; wdata = d;
    @(negedge clk);
    seen_gnt = gnt; seen_rvalid = rvalid; seen_rdata = rdata;
    check("rvalid", rvalid, exp_rvalid);
    check("rdata", rdata, exp_rdata);
    win = pick(r);
    e_gnt = '0; e_wr = 1'b0; e_addr = '0; e_data = '0;
    if (win >= 0) begin
      e_gnt[win] = 1'b1;
      e_wr       = w[win];
      e_addr     = a[win*MDATAW +: MDATAW];
      e_data     = d[win*NBDATA +: NBDATA];
    end
    check("gnt", gnt, e_gnt);
    check("mem_wr", mem_wr, e_wr);
    check("mem_addr", mem_addr, e_addr);
    check("mem_data_out", mem_data_out, e_data);
    @(posedge clk);
    exp_rvalid = '0;
    if (win >= 0) begin
      if (!e_wr) begin
        exp_rvalid = e_gnt;
        exp_rdata  = mem_img[e_addr];
      end
      m_last = win;
      if (LOCK_ON) begin
        if (m_locked && win == m_owner) begin
          m_cnt++;
          if (!l[win] || m_cnt == LOCKMAX) m_locked = 1'b0;
        end else if (l[win]) begin
          m_locked = 1'b1;
          m_owner  = win;
          m_cnt    = 0;
        end else begin
          m_locked = 1'b0;
        end
      end
    end else begin
      m_locked = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [NREQ*MDATAW-1:0] ra;
    logic [NREQ*NBDATA-1:0] rd;
    rst = 1'b0; req = '0; wr = '0; lock = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
    mem_img[8'h20] = 32'hDEADBEEF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", rvalid, '0);
    check("reset_rdata", rdata, '0);
    check("reset_gnt", gnt, '0);
    rst = 1'b1;

    // Reset priority: 01, 10, 01, 10
    for (int n = 0; n < 4; n++) begin
      step(2'b11, 2'b00, 2'b00, '0, '0);
      check("rst_prio", seen_gnt, (n % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Read by requester 1
    step(2'b10, 2'b00, 2'b00, {8'h20, 8'h00}, '0);
    step(2'b00, 2'b00, 2'b00, '0, '0);
    check("read_rvalid", seen_rvalid, 2'b10);
    check("read_rdata", seen_rdata, 32'hDEADBEEF);

    // Write by requester 0
    step(2'b01, 2'b01, 2'b00, {8'h00, 8'h05}, {32'h0, 32'h12345678});
    step(2'b00, 2'b00, 2'b00, '0, '0);
    check("write_no_rvalid", seen_rvalid, 2'b00);

    // Idle gap keeps the order: last grant was 0, so 1 wins next
    step(2'b00, 2'b00, 2'b00, 16'hA5A5, '1);
    step(2'b11, 2'b00, 2'b00, '0, '0);
    check("idle_order", seen_gnt, 2'b10);

    // Reset in the cycle after a granted read
    step(2'b10, 2'b00, 2'b00, {8'h20, 8'h00}, '0);
    check("midrd_pending", rvalid, 2'b10);
    rst = 1'b0;
    #1;
    check("midrd_rvalid", rvalid, 2'b00);
    check("midrd_rdata", rdata, '0);
    model_reset();
    rst = 1'b1;
    step(2'b11, 2'b00, 2'b00, '0, '0);
    check("midrd_prio", seen_gnt, 2'b01);

`ifdef DMEM_ARB_LOCK_EN
    step(2'b10, 2'b00, 2'b00, '0, '0);
    for (int n = 0; n < 5; n++) begin
      step(2'b11, 2'b00, 2'b01, '0, '0);
      check("lock_hold", seen_gnt, 2'b01);
    end
    step(2'b11, 2'b00, 2'b01, '0, '0);
    check("lock_release", seen_gnt, 2'b10);
`endif

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra[i*MDATAW +: MDATAW] = MDATAW'($urandom);
        rd[i*NBDATA +: NBDATA] = $urandom;
      end
      step(NREQ'($urandom_range(0, (1 << NREQ) - 1)),
           NREQ'($urandom_range(0, (1 << NREQ) - 1)),
           NREQ'($urandom_range(0, (1 << NREQ) - 1)), ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
